// File: rtl/jtcop_rom_server.sv
// Graphics ROM fetch responder: four 32-bit clients, each with a one-entry cache,
// share one SDRAM read port through a round-robin arbiter.
module jtcop_rom_server #(
  parameter logic [21:0] OFFSET0 = 22'h00_0000,
  parameter logic [21:0] OFFSET1 = 22'h04_0000,
  parameter logic [21:0] OFFSET2 = 22'h08_0000,
  parameter logic [21:0] OFFSET3 = 22'h0C_0000
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        downloading,
  input  logic        slot0_cs,
  input  logic [16:0] slot0_addr,
  output logic [31:0] slot0_data,
  output logic        slot0_ok,
  input  logic        slot1_cs,
  input  logic [16:0] slot1_addr,
  output logic [31:0] slot1_data,
  output logic        slot1_ok,
  input  logic        slot2_cs,
  input  logic [16:0] slot2_addr,
  output logic [31:0] slot2_data,
  output logic        slot2_ok,
  input  logic        slot3_cs,
  input  logic [16:0] slot3_addr,
  output logic [31:0] slot3_data,
  output logic        slot3_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [31:0] sdram_din
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  sel_q, sel_d;
  logic [16:0] req_addr_q, req_addr_d;
  logic        req_q, req_d;
  logic [21:0] addr_q, addr_d;
  logic        discard_q, discard_d;
  logic        fill;

  logic [16:0] caddr_q [4];
  logic [31:0] cdata_q [4];
  logic [3:0]  cvalid_q;

  logic [3:0]  cs_w;
  logic [16:0] addr_w [4];
  logic [21:0] offset_w [4];
  logic [3:0]  hit_w, miss_w;
  logic [1:0]  idx, pick;
  logic        found;

  assign cs_w = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign addr_w[0] = slot0_addr;
  assign addr_w[1] = slot1_addr;
  assign addr_w[2] = slot2_addr;
  assign addr_w[3] = slot3_addr;
  assign offset_w[0] = OFFSET0;
  assign offset_w[1] = OFFSET1;
  assign offset_w[2] = OFFSET2;
  assign offset_w[3] = OFFSET3;

  always_comb begin
    hit_w  = '0;
    miss_w = '0;
    for (int i = 0; i < 4; i++) begin
      hit_w[i]  = cvalid_q[i] && (caddr_q[i] == addr_w[i]);
      miss_w[i] = cs_w[i] && !hit_w[i];
    end
  end

  // Lowest k wins, so the slot right after the last served one has priority.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr_q + 2'(k);
      if (miss_w[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    req_addr_d = req_addr_q;
    req_d      = req_q;
    addr_d     = addr_q;
    discard_d  = discard_q | downloading;
    fill       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        if (!downloading && found) begin
          sel_d      = pick;
          req_addr_d = addr_w[pick];
          req_d      = 1'b1;
          addr_d     = {addr_w[pick], 1'b0} + offset_w[pick];
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (sdram_rdy) begin
          fill    = 1'b1;
          ptr_d   = sel_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd3;
      sel_q      <= 2'd0;
      req_addr_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      req_addr_q <= req_addr_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
    end
  end

  // A fill that overlapped any part of a download is dropped entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cvalid_q <= '0;
      for (int i = 0; i < 4; i++) begin
        caddr_q[i] <= '0;
        cdata_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (downloading) begin
          cvalid_q[i] <= 1'b0;
        end else if (fill && !discard_q && sel_q == 2'(i)) begin
          cvalid_q[i] <= 1'b1;
          caddr_q[i]  <= req_addr_q;
          cdata_q[i]  <= sdram_din;
        end
      end
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign slot0_data = cdata_q[0];
  assign slot1_data = cdata_q[1];
  assign slot2_data = cdata_q[2];
  assign slot3_data = cdata_q[3];
  assign slot0_ok   = cs_w[0] && hit_w[0];
  assign slot1_ok   = cs_w[1] && hit_w[1];
  assign slot2_ok   = cs_w[2] && hit_w[2];
  assign slot3_ok   = cs_w[3] && hit_w[3];

endmodule
